finv_unit: RTL and testbench



---
 rtl/finv_pkg.sv | 60 ++++++
 rtl/finv_table.sv | 29 ++
 rtl/finv_unit.sv | 119 +++++++++++
 tb/tb_finv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/finv_pkg.sv
// finv_pkg: shared constants, types and coefficient generator for the finv_unit reciprocal.
//
// Contents:
//   - float field widths and exponent bias
//   - special-value constants (infinity exponent, quiet-NaN mantissa)
//   - default table index width and gradient fraction bits
//   - finv_coef(): chord-midpoint linear fit of 2/x for one mantissa segment.
//     It is evaluated at elaboration only, so the ROM is constant data.
package finv_pkg;

   localparam int unsigned FINV_EXP_W      = 8;
   localparam int unsigned FINV_MAN_W      = 23;
   localparam int unsigned FINV_BIAS       = 127;
   localparam logic [7:0]  FINV_EXP_INF    = 8'hFF;
   localparam logic [22:0] FINV_QNAN_MAN   = 23'h400000;
   localparam int unsigned FINV_TABLE_BITS = 10;
   // Extra fraction bits carried by the gradient below one ulp per segment.
   localparam int unsigned FINV_FRAC_BITS  = 8;

   typedef struct packed {
      logic [FINV_MAN_W-1:0] a;  // intercept at segment start, in result ulps
      logic [FINV_MAN_W-1:0] b;  // drop across the segment, scaled by 2^FINV_FRAC_BITS
   } finv_coef_t;

   // Result mantissa over segment seg is 2/x - 1 with x = 1 + (seg + t) / 2^table_bits.
   // Internal values are in result ulps scaled by 2^16.
   function automatic finv_coef_t finv_coef(input int unsigned table_bits,
                                            input int unsigned seg);
      logic [63:0] k;
      logic [63:0] x;
      logic [63:0] y0;
      logic [63:0] y1;
      logic [63:0] drop;
      logic [63:0] den;
      logic [63:0] gap;
      logic [63:0] lin;
      logic [63:0] a_raw;
      logic [63:0] b_raw;
      finv_coef_t  c;
      k    = 64'd1 << (40 + table_bits);
      x    = (64'd1 << table_bits) + 64'(seg);
      y0   = k / x;
      y1   = k / (x + 64'd1);
      drop = y0 - y1;
      // Max chord-to-curve gap ~ f''/8 evaluated at the segment midpoint.
      den  = (64'd2 * x + 64'd1) * (64'd2 * x + 64'd1) * (64'd2 * x + 64'd1);
      gap  = (64'd2 * k) / den;
      // Line sits halfway between chord and tangent to balance the error.
      lin  = y0 - (gap >> 1);
      // Flooring the intercept here centres the later floor of the product term.
      a_raw = (lin >> 16) - (64'd1 << FINV_MAN_W);
      b_raw = (drop + (64'd1 << (15 - FINV_FRAC_BITS))) >> (16 - FINV_FRAC_BITS);
      if (a_raw > 64'h7F_FFFF) a_raw = 64'h7F_FFFF;
      if (b_raw > 64'h7F_FFFF) b_raw = 64'h7F_FFFF;
      c.a = 23'(a_raw);
      c.b = 23'(b_raw);
      return c;
   endfunction

endpackage

// File: rtl/finv_table.sv
// finv_table: combinational coefficient ROM for the reciprocal mantissa approximation.
//
// Ports:
//   idx    - mantissa MSBs selecting one of 2^TABLE_BITS segments
//   coef_a - 23-bit intercept for the segment
//   coef_b - 23-bit gradient for the segment
module finv_table
   import finv_pkg::*;
#(
   parameter int unsigned TABLE_BITS = FINV_TABLE_BITS
) (
   input  logic [TABLE_BITS-1:0] idx,
   output logic [FINV_MAN_W-1:0] coef_a,
   output logic [FINV_MAN_W-1:0] coef_b
);

   localparam int unsigned ENTRIES = 2 ** TABLE_BITS;

   finv_coef_t rom [ENTRIES];

   for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
      localparam finv_coef_t COEF = finv_coef(TABLE_BITS, g);
      assign rom[g] = COEF;
   end

   assign coef_a = rom[idx].a;
   assign coef_b = rom[idx].b;

endmodule

// File: rtl/finv_unit.sv
// finv_unit: single-precision reciprocal, dest = 1.0 / src, one-cycle latency.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears dest/ovf/udf
//   src   - IEEE-754 single operand, one per cycle
//   dest  - registered reciprocal
//   ovf   - registered divide-by-zero flag (zero or denormal operand)
//   udf   - registered underflow flag (result below smallest normal)
//
// Build option: define FINV_NAN_EN to return a quiet NaN for NaN operands;
// otherwise NaN operands are handled like infinity (signed zero).
module finv_unit
   import finv_pkg::*;
#(
   parameter int unsigned TABLE_BITS = FINV_TABLE_BITS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] src,
   output logic [31:0] dest,
   output logic        ovf,
   output logic        udf
);

   localparam int unsigned DBITS = FINV_MAN_W - TABLE_BITS;
   localparam int unsigned SHIFT = DBITS + FINV_FRAC_BITS;
   localparam int unsigned MULW  = FINV_MAN_W + DBITS;

   localparam logic [FINV_MAN_W-1:0] MAN_ZERO = '0;
   localparam logic [FINV_EXP_W-1:0] EXP_POW  = FINV_EXP_W'(2 * FINV_BIAS);
   localparam logic [FINV_EXP_W-1:0] EXP_GEN  = FINV_EXP_W'(2 * FINV_BIAS - 1);

   logic                  s;
   logic [FINV_EXP_W-1:0] e;
   logic [FINV_MAN_W-1:0] m;

   logic [TABLE_BITS-1:0] idx;
   logic [DBITS-1:0]      d_low;
   logic [FINV_MAN_W-1:0] coef_a;
   logic [FINV_MAN_W-1:0] coef_b;
   logic [MULW-1:0]       prod;
   logic [FINV_MAN_W:0]   slope;
   logic [FINV_MAN_W:0]   diff;
   logic [FINV_MAN_W-1:0] man_gen;

   logic [31:0] dest_d, dest_q;
   logic        ovf_d, ovf_q;
   logic        udf_d, udf_q;

   assign s = src[31];
   assign e = src[30:23];
   assign m = src[22:0];

   assign idx   = m[FINV_MAN_W-1 -: TABLE_BITS];
   assign d_low = m[DBITS-1:0];

   finv_table #(
      .TABLE_BITS(TABLE_BITS)
   ) u_table (
      .idx   (idx),
      .coef_a(coef_a),
      .coef_b(coef_b)
   );

   assign prod  = MULW'(coef_b) * MULW'(d_low);
   assign slope = (FINV_MAN_W + 1)'(prod >> SHIFT);
   assign diff  = {1'b0, coef_a} - slope;
   // Last segment can dip a fraction of an ulp below 1.0; saturate at zero mantissa.
   assign man_gen = diff[FINV_MAN_W] ? MAN_ZERO : diff[FINV_MAN_W-1:0];

   always_comb begin
      dest_d = 32'h0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
      if (e == '0) begin
         dest_d = {s, FINV_EXP_INF, MAN_ZERO};
         ovf_d  = 1'b1;
      end else if (e == FINV_EXP_INF) begin
`ifdef FINV_NAN_EN
         if (m != '0) dest_d = {s, FINV_EXP_INF, FINV_QNAN_MAN};
         else         dest_d = {s, 31'h0};
`else
         dest_d = {s, 31'h0};
`endif
      end else if (m == '0) begin
         if (e >= EXP_POW) begin
            dest_d = {s, 31'h0};
            udf_d  = 1'b1;
         end else begin
            dest_d = {s, EXP_POW - e, MAN_ZERO};
         end
      end else begin
         if (e >= EXP_GEN) begin
            dest_d = {s, 31'h0};
            udf_d  = 1'b1;
         end else begin
            dest_d = {s, EXP_GEN - e, man_gen};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_q <= 32'h0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         dest_q <= dest_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   assign dest = dest_q;
   assign ovf  = ovf_q;
   assign udf  = udf_q;

endmodule

// File: tb/tb_finv_unit.sv
// tb_finv_unit: self-checking bench for finv_unit against a real-arithmetic reciprocal model.
module tb_finv_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] src;
   logic [31:0] dest;
   logic        ovf;
   logic        udf;

   int total;
   int bad;

   finv_unit u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .src  (src),
      .dest (dest),
      .ovf  (ovf),
      .udf  (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 1/x in double precision, rounded to nearest single.
   // approx=1 marks a finite normal result that may differ by up to 4 ulp.
   function automatic void ref_model(input logic [31:0] x, output logic [31:0] d,
                                     output logic o, output logic u, output logic approx);
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      real         xr;
      real         r;
      real         tiny;
      logic [63:0] rb;
      logic [10:0] ed;
      logic [30:0] mag;
      s = x[31];
      e = x[30:23];
      m = x[22:0];
      d = 32'h0;
      o = 1'b0;
      u = 1'b0;
      approx = 1'b0;
      if (e == 8'd0) begin
         d = {s, 8'hFF, 23'h0};
         o = 1'b1;
      end else if (e == 8'hFF) begin
`ifdef FINV_NAN_EN
         d = (m != 23'd0) ? {s, 8'hFF, 23'h400000} : {s, 31'h0};
`else
         d = {s, 31'h0};
`endif
      end else begin
         xr   = $bitstoreal({1'b0, 11'(e) + 11'd896, m, 29'd0});
         r    = 1.0 / xr;
         tiny = $bitstoreal({1'b0, 11'd897, 52'd0});
         if (r < tiny) begin
            d = {s, 31'h0};
            u = 1'b1;
         end else begin
            rb  = $realtobits(r);
            ed  = rb[62:52] - 11'd896;
            mag = {ed[7:0], rb[51:29]} + 31'(rb[28]);
            d   = {s, mag};
            approx = (m != 23'd0);
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] x);
      logic [31:0] exp_d;
      logic        exp_o;
      logic        exp_u;
      logic        approx;
      int          diff;
      ref_model(x, exp_d, exp_o, exp_u, approx);
      src = x;
      @(posedge clk);
      #1;
      total++;
      if (approx) begin
         diff = int'(dest[30:0]) - int'(exp_d[30:0]);
         if (diff < 0) diff = -diff;
         assert ((dest[31] === exp_d[31]) && (diff <= 4)) else begin
            bad++;
            $error("FAIL %s dest src=%h got %h want %h (+-4 ulp)", tag, x, dest, exp_d);
         end
      end else begin
         assert (dest === exp_d) else begin
            bad++;
            $error("FAIL %s dest src=%h got %h want %h", tag, x, dest, exp_d);
         end
      end
      total++;
      assert ({ovf, udf} === {exp_o, exp_u}) else begin
         bad++;
         $error("FAIL %s flags src=%h got ovf/udf %b%b want %b%b", tag, x, ovf, udf,
                exp_o, exp_u);
      end
   endtask

   task automatic check_const(input string tag, input logic [31:0] x, input logic [31:0] want,
                              input logic want_o, input logic want_u);
      src = x;
      @(posedge clk);
      #1;
      total++;
      assert ({dest, ovf, udf} === {want, want_o, want_u}) else begin
         bad++;
         $error("FAIL %s src=%h got %h/%b%b want %h/%b%b", tag, x, dest, ovf, udf, want,
                want_o, want_u);
      end
   endtask

   initial begin
      logic [31:0] r;
      int unsigned pick;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      src   = 32'h3F80_0000;
      #12;
      total++;
      assert ({dest, ovf, udf} === 34'h0) else begin
         bad++;
         $error("FAIL reset got %h/%b%b want 0", dest, ovf, udf);
      end
      @(negedge clk);
      rst_n = 1'b1;

      check_const("one",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
      check_const("two",    32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0);
      check_const("four",   32'h4080_0000, 32'h3E80_0000, 1'b0, 1'b0);
      check_const("mhalf",  32'hBF00_0000, 32'hC000_0000, 1'b0, 1'b0);
      check("three",        32'h4040_0000);
      check_const("zero",   32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
      check_const("ndenorm",32'h8000_0001, 32'hFF80_0000, 1'b1, 1'b0);
      check_const("udfpow", 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1);
      check_const("udfmax", 32'hFF7F_FFFF, 32'h8000_0000, 1'b0, 1'b1);
      check_const("inf",    32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0);
`ifdef FINV_NAN_EN
      check_const("nan",    32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0);
`else
      check_const("nan",    32'h7FC0_0001, 32'h0000_0000, 1'b0, 1'b0);
`endif
      check("edgelo", 32'h3F80_0001);
      check("edgehi", 32'h3FFF_FFFF);
      check("lastok", 32'h7E7F_FFFF);

      // Async reset between operands: ovf set, then cleared without a clock edge.
      check_const("pre_rst", 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      assert ({dest, ovf, udf} === 34'h0) else begin
         bad++;
         $error("FAIL async_rst got %h/%b%b want 0", dest, ovf, udf);
      end
      src = 32'h4000_0000;
      @(posedge clk);
      #1;
      total++;
      assert ({dest, ovf, udf} === 34'h0) else begin
         bad++;
         $error("FAIL held_rst got %h/%b%b want 0", dest, ovf, udf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      check_const("post_rst", 32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0);

      for (int i = 0; i < 10000; i++) begin
         r    = $urandom;
         pick = $urandom_range(0, 15);
         case (pick)
            0: r[30:23] = 8'd0;
            1: r[30:23] = 8'hFF;
            2: r[30:23] = 8'd253 + 8'($urandom_range(0, 1));
            3: r[22:0]  = 23'd0;
            default: ;
         endcase
         check("rand", r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
